// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
// Multi-cycle control FSM for the RV32I core. Fetches through an
// instruction-memory request/ready handshake, classifies ir[6:0], drives the
// SignExtender opcode, ALU/writeback/PC selects and data-memory requests, and
// retires one instruction at a time. Illegal opcodes and memory timeouts end
// in a sticky trap that only reset clears.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   imem_req/ready    instruction fetch handshake (imem_rdata is latched into
//                     IR by the datapath when ir_write pulses)
//   ir                current IR contents
//   imm_opcode        opcode to SignExtender, ir[6:0] from DECODE onward
//   alu_src_a/b/op    ALU operand selects and function (valid in EXECUTE)
//                     alu_op = {funct7[5], funct3}: 0000 ADD, 1000 SUB,
//                     0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL,
//                     1101 SRA, 0110 OR, 0111 AND
//   branch_cond       comparator result for the current B-type
//   pc_write, pc_sel  PC update pulse and next-PC source
//   dmem_req/we/ready data memory handshake
//   reg_write, wb_sel register-file write pulse and writeback source
//   instret           retired-instruction count (wraps)
//   trap, trap_cause  sticky fault flag: 01 illegal, 10 imem, 11 dmem timeout

module riscv_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic             ir_write,
   input  logic [31:0]      ir,
   output logic [6:0]       imm_opcode,
   output logic [1:0]       alu_src_a,
   output logic             alu_src_b,
   output logic [3:0]       alu_op,
   input  logic             branch_cond,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic [CNT_W-1:0] instret,
   output logic             trap,
   output logic [1:0]       trap_cause
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM    = 2'b10;
   localparam logic [1:0] CAUSE_DMEM    = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WRITEBACK,
      S_TRAP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              live;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_hit;
   logic              waiting;
   logic              trap_set;
   logic [1:0]        cause_nxt;

   logic [6:0] opc;
   logic [2:0] funct3;
   logic       f7b5;
   logic       is_r, is_i, is_load, is_store, is_branch;
   logic       is_jalr, is_jal, is_lui, is_auipc, is_legal;
   logic [1:0] dec_src_a;
   logic       dec_src_b;
   logic [3:0] dec_alu_op;

   // Only opcode, funct3 and funct7[5] steer control; the word itself goes to the datapath.
   logic unused_bits;
   assign unused_bits = ^{imem_rdata, ir[31], ir[29:15], ir[11:7]};

   assign opc    = ir[6:0];
   assign funct3 = ir[14:12];
   assign f7b5   = ir[30];

   assign is_r      = (opc == OP_R);
   assign is_i      = (opc == OP_I);
   assign is_load   = (opc == OP_LOAD);
   assign is_store  = (opc == OP_STORE);
   assign is_branch = (opc == OP_BRANCH);
   assign is_jalr   = (opc == OP_JALR);
   assign is_jal    = (opc == OP_JAL);
   assign is_lui    = (opc == OP_LUI);
   assign is_auipc  = (opc == OP_AUIPC);
   assign is_legal  = is_r | is_i | is_load | is_store | is_branch |
                      is_jalr | is_jal | is_lui | is_auipc;

   assign wait_hit = (wait_cnt == WAIT_LAST);
   assign waiting  = (imem_req & ~imem_ready) | (dmem_req & ~dmem_ready);

   // ALU operand/function decode; funct7[5] only matters for R-type and I-type shifts right.
   always_comb begin
      dec_src_a  = 2'd0;
      dec_src_b  = 1'b1;
      dec_alu_op = 4'b0000;
      if (is_r) begin
         dec_src_b  = 1'b0;
         dec_alu_op = {f7b5, funct3};
      end else if (is_i) begin
         dec_alu_op = {(funct3 == 3'b101) & f7b5, funct3};
      end else if (is_branch) begin
         dec_src_b  = 1'b0;
         dec_alu_op = 4'b1000;
      end else if (is_jal || is_auipc) begin
         dec_src_a  = 2'd1;
      end else if (is_lui) begin
         dec_src_a  = 2'd2;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      state_nxt  = state;
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      imm_opcode = 7'd0;
      alu_src_a  = 2'd0;
      alu_src_b  = 1'b0;
      alu_op     = 4'd0;
      pc_write   = 1'b0;
      pc_sel     = 2'd0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      reg_write  = 1'b0;
      wb_sel     = 2'd0;
      trap_set   = 1'b0;
      cause_nxt  = 2'b00;
      case (state)
         S_FETCH: begin
            // Held quiet until the first clock edge after reset release.
            if (live) begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_write  = 1'b1;
                  state_nxt = S_DECODE;
               end else if (wait_hit) begin
                  trap_set  = 1'b1;
                  cause_nxt = CAUSE_IMEM;
                  state_nxt = S_TRAP;
               end
            end
         end
         S_DECODE: begin
            imm_opcode = opc;
            if (is_legal) begin
               state_nxt = S_EXECUTE;
            end else begin
               trap_set  = 1'b1;
               cause_nxt = CAUSE_ILLEGAL;
               state_nxt = S_TRAP;
            end
         end
         S_EXECUTE: begin
            imm_opcode = opc;
            alu_src_a  = dec_src_a;
            alu_src_b  = dec_src_b;
            alu_op     = dec_alu_op;
            if (is_branch) begin
               pc_write  = 1'b1;
               pc_sel    = branch_cond ? 2'd1 : 2'd0;
               state_nxt = S_FETCH;
            end else if (is_load || is_store) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WRITEBACK;
            end
         end
         S_MEM: begin
            imm_opcode = opc;
            dmem_req   = 1'b1;
            dmem_we    = is_store;
            if (dmem_ready) begin
               if (is_store) begin
                  pc_write  = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WRITEBACK;
               end
            end else if (wait_hit) begin
               trap_set  = 1'b1;
               cause_nxt = CAUSE_DMEM;
               state_nxt = S_TRAP;
            end
         end
         S_WRITEBACK: begin
            imm_opcode = opc;
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            state_nxt  = S_FETCH;
            if (is_load) begin
               wb_sel = 2'd1;
            end else if (is_jal || is_jalr) begin
               wb_sel = 2'd2;
            end else if (is_lui) begin
               wb_sel = 2'd3;
            end
            if (is_jal) begin
               pc_sel = 2'd1;
            end else if (is_jalr) begin
               pc_sel = 2'd2;
            end
         end
         S_TRAP: begin
            state_nxt = S_TRAP;
         end
         default: begin
            state_nxt = S_FETCH;
         end
      endcase
   end

   // State register plus the one-shot reset-exit flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
         live  <= 1'b0;
      end else begin
         state <= state_nxt;
         live  <= 1'b1;
      end
   end

   // Memory wait counter: restarts on every state change, counts unanswered requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state_nxt != state) begin
         wait_cnt <= '0;
      end else if (waiting) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Retired-instruction counter: every retirement pulses pc_write exactly once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret <= '0;
      end else if (pc_write) begin
         instret <= instret + CNT_W'(1);
      end
   end

   // Sticky trap flag and cause.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap       <= 1'b0;
         trap_cause <= 2'b00;
      end else if (trap_set) begin
         trap       <= 1'b1;
         trap_cause <= cause_nxt;
      end
   end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Testbench for riscv_multicycle_ctrl: directed scenarios followed by random
// instruction streams, each cycle compared against an instruction-level
// reference schedule built from the opcode class and the memory wait counts.

module tb_riscv_multicycle_ctrl;

   localparam int TO = 16;

   localparam logic [6:0] O_R  = 7'b0110011;
   localparam logic [6:0] O_I  = 7'b0010011;
   localparam logic [6:0] O_LD = 7'b0000011;
   localparam logic [6:0] O_ST = 7'b0100011;
   localparam logic [6:0] O_BR = 7'b1100011;
   localparam logic [6:0] O_JR = 7'b1100111;
   localparam logic [6:0] O_JL = 7'b1101111;
   localparam logic [6:0] O_LU = 7'b0110111;
   localparam logic [6:0] O_AU = 7'b0010111;

   logic        clk, rst_n;
   logic        imem_req, imem_ready, ir_write, alu_src_b, branch_cond;
   logic        pc_write, dmem_req, dmem_we, dmem_ready, reg_write, trap;
   logic [31:0] imem_rdata, ir, instret;
   logic [6:0]  imm_opcode;
   logic [1:0]  alu_src_a, pc_sel, wb_sel, trap_cause;
   logic [3:0]  alu_op;
   logic [26:0] obs_v;

   riscv_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .ir_write(ir_write), .ir(ir), .imm_opcode(imm_opcode),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .branch_cond(branch_cond), .pc_write(pc_write), .pc_sel(pc_sel),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .reg_write(reg_write), .wb_sel(wb_sel), .instret(instret),
      .trap(trap), .trap_cause(trap_cause)
   );

   assign obs_v = {imem_req, ir_write, imm_opcode, alu_src_a, alu_src_b, alu_op,
                   pc_write, pc_sel, dmem_req, dmem_we, reg_write, wb_sel,
                   trap, trap_cause};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected values for the cycle about to be sampled.
   logic        e_ireq, e_irw, e_b, e_pcw, e_dreq, e_dwe, e_rw, e_trap;
   logic [6:0]  e_imm;
   logic [1:0]  e_a, e_pcs, e_wb, e_cause;
   logic [3:0]  e_op;
   logic [31:0] e_instret;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      e_ireq = 0; e_irw = 0; e_imm = 0; e_a = 0; e_b = 0; e_op = 0;
      e_pcw = 0; e_pcs = 0; e_dreq = 0; e_dwe = 0; e_rw = 0; e_wb = 0;
   endtask

   task automatic noise();
      imem_ready  = 1'($urandom);
      dmem_ready  = 1'($urandom);
      branch_cond = 1'($urandom);
      imem_rdata  = $urandom;
   endtask

   // Compare one cycle at the falling edge, then advance to just past the next rising edge.
   task automatic tick(input string tag);
      logic [26:0] ev;
      @(negedge clk);
      ev = {e_ireq, e_irw, e_imm, e_a, e_b, e_op, e_pcw, e_pcs, e_dreq, e_dwe,
            e_rw, e_wb, e_trap, e_cause};
      check({tag, ":outputs"}, 32'(obs_v), 32'(ev));
      check({tag, ":instret"}, instret, e_instret);
      if (e_pcw) e_instret = e_instret + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic hold_trap(input int n);
      clr();
      for (int i = 0; i < n; i++) begin
         noise();
         tick("trap_hold");
      end
   endtask

   // Reset from just past a rising edge; release it the same way so the exit cycle is checked.
   task automatic do_reset(input string tag);
      noise();
      rst_n = 1'b0;
      #1;
      check({tag, ":rst_outputs"}, 32'(obs_v), 32'd0);
      check({tag, ":rst_instret"}, instret, 32'd0);
      e_trap = 0; e_cause = 0; e_instret = 0;
      clr();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      noise();
      tick({tag, ":rst_exit"});
   endtask

   // ALU expectations by instruction kind.
   task automatic exp_alu(input logic [31:0] w, output logic [1:0] a,
                          output logic b, output logic [3:0] op);
      logic [2:0] f3;
      f3 = w[14:12];
      a = 2'd0; b = 1'b1; op = 4'b0000;
      case (w[6:0])
         O_R:        begin b = 1'b0; op = {w[30], f3}; end
         O_I:        op = (f3 == 3'b101) ? {w[30], f3} : {1'b0, f3};
         O_BR:       begin b = 1'b0; op = 4'b1000; end
         O_JL, O_AU: a = 2'd1;
         O_LU:       a = 2'd2;
         default:    ;
      endcase
   endtask

   // Drive one instruction end to end; fw/mw are memory wait cycles (TO means time out).
   task automatic run_instr(input logic [31:0] w, input int fw, input int mw,
                            input logic bc, input bit abort_mem);
      logic [6:0] op;
      bit legal, ld, st;
      op    = w[6:0];
      legal = op inside {O_R, O_I, O_LD, O_ST, O_BR, O_JR, O_JL, O_LU, O_AU};
      ld    = (op == O_LD);
      st    = (op == O_ST);
      for (int i = 0; i < fw && i < TO; i++) begin
         clr(); e_ireq = 1; noise(); imem_ready = 1'b0;
         tick("fetch_wait");
      end
      if (fw >= TO) begin
         e_trap = 1; e_cause = 2'b10;
         hold_trap(3);
         return;
      end
      clr(); e_ireq = 1; e_irw = 1; noise(); imem_ready = 1'b1; imem_rdata = w;
      tick("fetch");
      ir = w;
      clr(); e_imm = op; noise();
      tick("decode");
      if (!legal) begin
         e_trap = 1; e_cause = 2'b01;
         hold_trap(4);
         return;
      end
      clr(); e_imm = op; noise();
      exp_alu(w, e_a, e_b, e_op);
      if (op == O_BR) begin
         branch_cond = bc; e_pcw = 1; e_pcs = bc ? 2'd1 : 2'd0;
         tick("exec_branch");
         return;
      end
      tick("execute");
      if (ld || st) begin
         for (int i = 0; i < mw && i < TO; i++) begin
            clr(); e_imm = op; e_dreq = 1; e_dwe = st; noise(); dmem_ready = 1'b0;
            tick("mem_wait");
         end
         if (mw >= TO) begin
            e_trap = 1; e_cause = 2'b11;
            hold_trap(3);
            return;
         end
         if (abort_mem) begin
            check("pre_abort_dmem_req", 32'(dmem_req), 32'd1);
            do_reset("mem_abort");
            return;
         end
         clr(); e_imm = op; e_dreq = 1; e_dwe = st; e_pcw = st; noise(); dmem_ready = 1'b1;
         tick(st ? "mem_store" : "mem_load");
         if (st) return;
      end
      clr(); e_imm = op; e_rw = 1; e_pcw = 1; noise();
      case (op)
         O_LD:    e_wb = 2'd1;
         O_JL:    begin e_wb = 2'd2; e_pcs = 2'd1; end
         O_JR:    begin e_wb = 2'd2; e_pcs = 2'd2; end
         O_LU:    e_wb = 2'd3;
         default: ;
      endcase
      tick("writeback");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0]  legal_ops [9];
      logic [31:0] r;
      legal_ops = '{O_R, O_I, O_LD, O_ST, O_BR, O_JR, O_JL, O_LU, O_AU};
      rst_n = 1'b0; ir = 32'd0;
      e_trap = 0; e_cause = 0; e_instret = 0;
      clr(); noise();
      @(posedge clk);
      #1;
      do_reset("init");

      run_instr(32'h01190933, 0, 0, 1'b0, 1'b0);       // R-type add
      run_instr(32'h0002a303, 0, 2, 1'b0, 1'b0);       // load, two waits
      run_instr(32'h0082a223, 1, 0, 1'b0, 1'b0);       // store
      run_instr(32'h014c6463, 0, 0, 1'b1, 1'b0);       // branch taken
      run_instr(32'h014c6463, 0, 0, 1'b0, 1'b0);       // branch not taken
      run_instr(32'h0000006f, 0, 0, 1'b0, 1'b0);       // JAL
      run_instr(32'h7ff080e7, 0, 0, 1'b0, 1'b0);       // JALR
      run_instr(32'h123452b7, 0, 0, 1'b0, 1'b0);       // LUI
      run_instr(32'h40b50533, TO - 1, 0, 1'b0, 1'b0);  // SUB, fetch ready on last allowed cycle
      run_instr(32'h0082a223, 0, TO - 1, 1'b0, 1'b0);  // store, dmem ready on last allowed cycle

      run_instr(32'h0000007f, 0, 0, 1'b0, 1'b0);       // illegal opcode
      do_reset("after_illegal");
      run_instr(32'h01190933, TO, 0, 1'b0, 1'b0);      // imem never ready
      do_reset("after_imem_to");
      run_instr(32'h0002a303, 0, TO, 1'b0, 1'b0);      // dmem never ready
      do_reset("after_dmem_to");
      run_instr(32'h00000013, 0, 0, 1'b0, 1'b0);       // nop before an aborted access
      run_instr(32'h0002a303, 0, 2, 1'b0, 1'b1);       // reset while in MEM

      for (int k = 0; k < 40; k++) begin
         r = $urandom;
         run_instr({r[31:7], legal_ops[$urandom_range(0, 8)]},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
